io_bus_initiator: RTL
=====================

Name: io_bus_initiator

Overview:
- Bus-master end of the memory-mapped IO port interface; drives write/read strobes, address and write data toward the IO port block and captures its returned data.
- Converts single-beat requests from the control path into bus transactions: write, read, and poll (repeated read until masked match or timeout).
- Sits between the core sequencer and io_ports; input port at address 10'h3FE, output port at 10'h3FF.

Parameters:
ADDR_WIDTH, 10, bus address width
DATA_WIDTH, 4, bus data width
READ_LATENCY, 1, clock edges between read strobe/address and valid returned data (>=1)
POLL_TIMEOUT, 255, maximum failed poll samples before timeout response (>=1)

Ports:
clk  input  1  system clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_req_valid  input  1  request present
out_req_ready  output  1  initiator idle, request accepted on valid&&ready at posedge
in_req_op  input  2  00 write, 01 read, 10 poll, 11 reserved
in_req_addr  input  ADDR_WIDTH  target address
in_req_data  input  DATA_WIDTH  write data / poll compare value
in_req_mask  input  DATA_WIDTH  poll compare mask
out_rsp_valid  output  1  one-cycle response pulse, no backpressure
out_rsp_data  output  DATA_WIDTH  read/poll sample or echoed write data
out_rsp_timeout  output  1  qualifies out_rsp_valid: poll timeout or reserved op
out_bus_write_en  output  1  bus write strobe
out_bus_read_en  output  1  bus read enable
out_bus_addr  output  ADDR_WIDTH  bus address
out_bus_data  output  DATA_WIDTH  bus write data
in_bus_data  input  DATA_WIDTH  bus read data from port block

Behaviour:
- One clock (clk); reset asynchronous, active-low (in_rst_n).
- Reset: out_req_ready=1; all other outputs 0; FSM IDLE; counters 0. Reset mid-transaction aborts immediately: strobes drop asynchronously, no response issued.
- All outputs registered. States: IDLE, WRITE, READ, POLL, RESP.
- IDLE: ready=1, bus outputs 0. Accept at posedge T0 with valid&&ready; op/addr/data/mask latched; ready=0 from T1. Request fields ignored when not accepted.
- WRITE: cycle T1 write_en=1, addr/data driven exactly one cycle. T2: RESP with rsp_valid=1, rsp_data=written data, timeout=0.
- READ: read_en=1 and addr driven for cycles T1..T(1+READ_LATENCY); in_bus_data sampled at posedge ending T(1+READ_LATENCY). Response in T(2+READ_LATENCY). Default: read_en T1-T2, rsp T3.
- POLL: read_en held continuously from T1. First sample at same edge as READ, then one sample every edge. Match = ((sample ^ req_data) & mask) == 0. Match -> read_en drops next cycle, RESP with rsp_data=sample, timeout=0. After POLL_TIMEOUT consecutive mismatches -> RESP with rsp_data=last sample, timeout=1. mask=0 matches on first sample.
- Reserved op 11: no bus activity; RESP in T1 with rsp_data=0, timeout=1.
- RESP: exactly one cycle; rsp_valid=1; out_req_ready=1 in the same cycle, so a new request may be accepted at the edge ending RESP (back-to-back; next bus strobe one cycle later). rsp_data/timeout return to 0 afterward.
- write_en and read_en never high simultaneously; bus addr/data 0 whenever both enables are 0.
- Poll counter saturates-free: width ceil(log2(POLL_TIMEOUT+1)), cleared on every accept.

Test Plan:
- Write: req op=00 addr=3FF data=1100 to io_ports -> write_en high one cycle T1, rsp_valid T2 data=1100, io_ports out_port=1100 after T1 edge.
- Read: io_ports in_port=1010, req op=01 addr=3FE -> read_en T1-T2, rsp_valid T3 data=1010 timeout=0.
- Poll match: in_port=0000, poll addr=3FE data=0100 mask=0100; set in_port=0110 after 5 cycles -> rsp data=0110 timeout=0, read_en drops next cycle.
- Poll timeout: POLL_TIMEOUT=8, in_port=0000, poll data=0001 mask=0001 -> after 8 samples rsp timeout=1 data=0000; mask=0000 -> rsp after first sample.
- Back-to-back and reserved: valid held with write then read -> second accepted at RESP edge, rsp order preserved; op=11 -> rsp T1 timeout=1, no strobes.
- Reset: in_rst_n low during POLL -> read_en 0 immediately, ready=1 after release, no rsp_valid.

Source files
------------

// File: rtl/io_bus_initiator.sv
// Bus master toward the IO port block: turns single-beat write/read/poll
// requests into strobed bus transactions and returns a one-cycle response.
//
// state | meaning
// IDLE  | ready for a request, bus quiet
// WRITE | write strobe driven for exactly one cycle
// READ  | read enable held until the returned data is sampled
// POLL  | read enable held, sampling every edge until match or timeout
// RESP  | one-cycle response pulse; the next request may be accepted here
module io_bus_initiator #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 4,
  parameter int READ_LATENCY = 1,
  parameter int POLL_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  in_rst_n,
  input  logic                  in_req_valid,
  output logic                  out_req_ready,
  input  logic [1:0]            in_req_op,
  input  logic [ADDR_WIDTH-1:0] in_req_addr,
  input  logic [DATA_WIDTH-1:0] in_req_data,
  input  logic [DATA_WIDTH-1:0] in_req_mask,
  output logic                  out_rsp_valid,
  output logic [DATA_WIDTH-1:0] out_rsp_data,
  output logic                  out_rsp_timeout,
  output logic                  out_bus_write_en,
  output logic                  out_bus_read_en,
  output logic [ADDR_WIDTH-1:0] out_bus_addr,
  output logic [DATA_WIDTH-1:0] out_bus_data,
  input  logic [DATA_WIDTH-1:0] in_bus_data
);

  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam int CNT_W = $clog2(POLL_TIMEOUT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_TIMEOUT - 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  typedef enum logic [2:0] {IDLE, WRITE, READ, POLL, RESP} state_t;

  state_t                state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] cmp_q, cmp_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  ready_d, rsp_valid_d, rsp_timeout_d;
  logic                  write_en_d, read_en_d;
  logic [DATA_WIDTH-1:0] rsp_data_d, bus_data_d;
  logic [ADDR_WIDTH-1:0] bus_addr_d;
  logic                  accept, sample_match;

  assign accept       = in_req_valid && out_req_ready;
  assign sample_match = ((in_bus_data ^ cmp_q) & mask_q) == '0;

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    cnt_d         = cnt_q;
    cmp_d         = cmp_q;
    mask_d        = mask_q;
    ready_d       = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_data_d    = '0;
    write_en_d    = 1'b0;
    read_en_d     = 1'b0;
    bus_addr_d    = '0;
    bus_data_d    = '0;

    case (state_q)
      IDLE: ready_d = 1'b1;
      WRITE: begin
        state_d     = RESP;
        ready_d     = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_data_d  = cmp_q;
      end
      READ, POLL: begin
        read_en_d  = 1'b1;
        bus_addr_d = out_bus_addr;
        // Latency countdown first; afterwards every edge is a sample edge.
        if (lat_q != '0) begin
          lat_d = lat_q - LAT_W'(1);
        end else if (state_q == READ || sample_match || cnt_q == CNT_LAST) begin
          state_d       = RESP;
          ready_d       = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = in_bus_data;
          rsp_timeout_d = (state_q == POLL) && !sample_match;
          read_en_d     = 1'b0;
          bus_addr_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase

    if (accept) begin
      ready_d = 1'b0;
      cmp_d   = in_req_data;
      mask_d  = in_req_mask;
      cnt_d   = '0;
      lat_d   = LAT_LOAD;
      case (in_req_op)
        OP_WRITE: begin
          state_d    = WRITE;
          write_en_d = 1'b1;
          bus_addr_d = in_req_addr;
          bus_data_d = in_req_data;
        end
        OP_READ: begin
          state_d    = READ;
          read_en_d  = 1'b1;
          bus_addr_d = in_req_addr;
        end
        OP_POLL: begin
          state_d    = POLL;
          read_en_d  = 1'b1;
          bus_addr_d = in_req_addr;
        end
        default: begin
          state_d       = RESP;
          ready_d       = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q          <= IDLE;
      lat_q            <= '0;
      cnt_q            <= '0;
      cmp_q            <= '0;
      mask_q           <= '0;
      out_req_ready    <= 1'b1;
      out_rsp_valid    <= 1'b0;
      out_rsp_data     <= '0;
      out_rsp_timeout  <= 1'b0;
      out_bus_write_en <= 1'b0;
      out_bus_read_en  <= 1'b0;
      out_bus_addr     <= '0;
      out_bus_data     <= '0;
    end else begin
      state_q          <= state_d;
      lat_q            <= lat_d;
      cnt_q            <= cnt_d;
      cmp_q            <= cmp_d;
      mask_q           <= mask_d;
      out_req_ready    <= ready_d;
      out_rsp_valid    <= rsp_valid_d;
      out_rsp_data     <= rsp_data_d;
      out_rsp_timeout  <= rsp_timeout_d;
      out_bus_write_en <= write_en_d;
      out_bus_read_en  <= read_en_d;
      out_bus_addr     <= bus_addr_d;
      out_bus_data     <= bus_data_d;
    end
  end

endmodule
